// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter fetch unit.
// It holds the FSM state encoding and the 32-entry jump-target table.
package pc_fetch_pkg;

  localparam int PC_W_DEF = 10;
  localparam int JT_W     = 8;
  localparam int JT_DEPTH = 32;
  localparam int JPTR_W   = 5;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [JT_W-1:0] jt_entry_t;

  // Jump targets. Entries above the program's last address end the program.
  localparam jt_entry_t JT [JT_DEPTH] = '{
    8'd1,   8'd4,   8'd6,   8'd0,   8'd3,   8'd9,   8'd7,   8'd2,
    8'd5,   8'd12,  8'd1,   8'd3,   8'd200, 8'd6,   8'd0,   8'd7,
    8'd2,   8'd4,   8'd8,   8'd5,   8'd1,   8'd255, 8'd6,   8'd3,
    8'd0,   8'd7,   8'd2,   8'd5,   8'd16,  8'd4,   8'd6,   8'd1
  };

endpackage

// File: rtl/pc_fetch_jump_lut.sv
// Combinational jump-target lookup: decoder jump index to a PC-wide target.
// Table entries are zero-extended to the program-counter width.
module jump_lut
  import pc_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [JPTR_W-1:0] jptr,
  output logic [PC_W-1:0]   target
);

  always_comb begin
    target = PC_W'(JT[jptr]);
  end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter sequencer: IDLE/RUN/DONE control, zero-bubble jumps through
// the jump table, stall hold and a saturating run-cycle counter.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] LAST_ADDR = PC_W'(1023)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              jump,
  input  logic [JPTR_W-1:0] jptr,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cyc_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  jmp_tgt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             jmp_oob;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  jump_lut #(
    .PC_W(PC_W)
  ) u_jump_lut (
    .jptr  (jptr),
    .target(jmp_tgt)
  );

  assign jmp_oob = (jmp_tgt > LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prog_ctr <= '0;
      cyc_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      cyc_cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    cnt_nxt   = cyc_cnt;
    unique case (state)
      ST_IDLE: begin
        pc_nxt = '0;
        if (start) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        // Stalled cycles still count; only the PC and control decisions freeze.
        cnt_nxt = sat_inc(cyc_cnt);
        if (!stall) begin
          if (jump) begin
            if (jmp_oob) state_nxt = ST_DONE;
            else         pc_nxt    = jmp_tgt;
          end else if (prog_ctr == LAST_ADDR) begin
            state_nxt = ST_DONE;
          end else begin
            pc_nxt = prog_ctr + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pc_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed program walks plus random control traffic,
// compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch;

  localparam int PC_W = 10;
  localparam int LAST = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            jump = 1'b0;
  logic [4:0]      jptr = '0;
  logic [PC_W-1:0] prog_ctr;
  logic            busy;
  logic            done;
  logic [15:0]     cyc_cnt;

  int checks = 0;
  int errors = 0;

  int tb_jt [32] = '{
    1, 4, 6, 0, 3, 9, 7, 2, 5, 12, 1, 3, 200, 6, 0, 7,
    2, 4, 8, 5, 1, 255, 6, 3, 0, 7, 2, 5, 16, 4, 6, 1
  };

  // Behavioural model state
  bit m_busy = 0;
  bit m_done = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  pc_fetch #(
    .PC_W(PC_W),
    .LAST_ADDR(PC_W'(LAST))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stall   (stall),
    .jump    (jump),
    .jptr    (jptr),
    .prog_ctr(prog_ctr),
    .busy    (busy),
    .done    (done),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic model_apply(input bit s, input bit st, input bit j, input int p);
    if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (!st) begin
        if (j) begin
          if (tb_jt[p] > LAST) begin m_busy = 0; m_done = 1; end
          else m_pc = tb_jt[p];
        end else if (m_pc == LAST) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_pc = (m_pc + 1) % (1 << PC_W);
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},   32'(prog_ctr), 32'(m_pc));
    check({tag, ".busy"}, 32'(busy),     32'(m_busy));
    check({tag, ".done"}, 32'(done),     32'(m_done));
    check({tag, ".cnt"},  32'(cyc_cnt),  32'(m_cnt));
  endtask

  task automatic step(input string tag, input bit s, input bit st, input bit j, input int p);
    start = s; stall = st; jump = j; jptr = 5'(p);
    @(posedge clk);
    model_apply(s, st, j, p);
    #1;
    compare_all(tag);
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #12;
    model_reset();
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    step("idle0", 0, 0, 0, 0);
    step("idle1", 0, 1, 1, 3);

    // Straight-line program 0..7
    step("launch", 1, 0, 0, 0);
    check("launch.pc_lit", 32'(prog_ctr), 32'd0);
    for (int i = 1; i <= 7; i++) step("seq", 0, 0, 0, 0);
    check("seq.pc7_lit", 32'(prog_ctr), 32'd7);
    step("seq_end", 0, 0, 0, 0);
    check("seq_end.done_lit", 32'(done), 32'd1);
    check("seq_end.cnt_lit", 32'(cyc_cnt), 32'd8);
    step("done_hold", 0, 0, 1, 2);

    // In-range jump from PC=3 through JT[2]=6
    step("relaunch1", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("to3", 0, 0, 0, 0);
    step("jmp2", 0, 0, 1, 2);
    check("jmp2.pc_lit", 32'(prog_ctr), 32'd6);
    step("after_jmp", 0, 0, 0, 0);
    step("end_jmp", 0, 0, 0, 0);
    check("end_jmp.done_lit", 32'(done), 32'd1);

    // Jump beats end-of-program at LAST; out-of-range target ends the run
    step("relaunch2", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("to7", 0, 0, 0, 0);
    step("jmp_last", 0, 0, 1, 0);
    check("jmp_last.pc_lit", 32'(prog_ctr), 32'd1);
    check("jmp_last.busy_lit", 32'(busy), 32'd1);
    step("jmp_oob", 0, 0, 1, 5);
    check("jmp_oob.pc_lit", 32'(prog_ctr), 32'd1);
    check("jmp_oob.done_lit", 32'(done), 32'd1);

    // Stall at PC=4 masks a jump request
    step("relaunch3", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("to4", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 2);
    check("stall.pc_lit", 32'(prog_ctr), 32'd4);
    check("stall.cnt_lit", 32'(cyc_cnt), 32'd7);
    step("unstall", 0, 0, 0, 0);
    async_reset("rst_mid_run");
    check("rst_mid_run.busy_lit", 32'(busy), 32'd0);

    // Start ignored while running; start in DONE relaunches
    step("relaunch4", 1, 0, 0, 0);
    step("r4a", 0, 0, 0, 0);
    step("start_in_run", 1, 0, 0, 0);
    check("start_in_run.pc_lit", 32'(prog_ctr), 32'd2);
    for (int i = 0; i < 6; i++) step("r4b", 0, 0, 0, 0);
    step("relaunch_done", 1, 0, 0, 0);
    check("relaunch_done.pc_lit", 32'(prog_ctr), 32'd0);
    check("relaunch_done.cnt_lit", 32'(cyc_cnt), 32'd0);

    // Counter saturation during a long stall
    start = 1'b0; stall = 1'b1; jump = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_apply(0, 1, 0, 0);
    end
    #1;
    compare_all("sat");
    check("sat.cnt_lit", 32'(cyc_cnt), 32'hFFFF);
    step("sat_more", 0, 1, 0, 0);

    // Random control traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 31)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
